// File: rtl/ahblite_waterlight_pkg.sv
//------------------------------------------------------------------------------
// ahblite_waterlight_pkg : register offsets, mode encodings, CTRL field layout
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ahblite_waterlight_pkg;

  // Word offsets, decoded from HADDR[3:2]
  localparam logic [1:0] c_OFS_CTRL    = 2'd0;
  localparam logic [1:0] c_OFS_SPEED   = 2'd1;
  localparam logic [1:0] c_OFS_PATTERN = 2'd2;
  localparam logic [1:0] c_OFS_COUNT   = 2'd3;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ROTL  = 2'd1,
    MODE_ROTR  = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam int c_CTRL_EN_BIT   = 0;
  localparam int c_CTRL_MODE_LSB = 1;
  localparam int c_CTRL_W        = 3;

endpackage

`default_nettype wire

// File: rtl/ahblite_waterlight_ctrl_engine.sv
//------------------------------------------------------------------------------
// waterlight_engine : step prescaler and LED pattern register
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module waterlight_engine
  import ahblite_waterlight_pkg::*;
#(
  parameter int LED_W   = 8,
  parameter int SPEED_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  mode_e              mode,
  input  logic [SPEED_W-1:0] speed,
  input  logic               restart,
  output logic [LED_W-1:0]   led,
  output logic               tick,
  output logic [SPEED_W-1:0] count
);

  logic [LED_W-1:0]   r_pattern;
  logic [SPEED_W-1:0] r_count;
  logic [LED_W-1:0]   w_init;
  logic [LED_W-1:0]   w_next;
  logic               w_active;

  assign w_active = en && (mode != MODE_OFF);

  always_comb begin
    w_init = '0;
    w_next = r_pattern;
    case (mode)
      MODE_ROTL: begin
        w_init = LED_W'(1);
        w_next = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
      end
      MODE_ROTR: begin
        w_init = {1'b1, {(LED_W-1){1'b0}}};
        w_next = {r_pattern[0], r_pattern[LED_W-1:1]};
      end
      MODE_BLINK: begin
        w_init = '1;
        w_next = ~r_pattern;
      end
      default: ;
    endcase
  end

  // A restart (mode/enable change) pre-empts a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_pattern <= '0;
    end else if (restart) begin
      r_count   <= speed;
      r_pattern <= w_active ? w_init : '0;
    end else if (!w_active) begin
      r_count   <= speed;
      r_pattern <= '0;
    end else if (r_count == '0) begin
      r_count   <= speed;
      r_pattern <= w_next;
    end else begin
      r_count   <= r_count - 1'b1;
    end
  end

  assign tick  = w_active && !restart && (r_count == '0);
  assign led   = r_pattern;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ahblite_waterlight_ctrl.sv
//------------------------------------------------------------------------------
// ahblite_waterlight_ctrl : zero-wait AHB-Lite slave driving an LED pattern engine
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ahblite_waterlight_ctrl
  import ahblite_waterlight_pkg::*;
#(
  parameter int LED_W   = 8,
  parameter int SPEED_W = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             HSEL,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic [2:0]       HSIZE,
  input  logic [3:0]       HPROT,
  input  logic             HWRITE,
  input  logic [31:0]      HWDATA,
  input  logic             HREADY,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  output logic             HRESP,
  output logic [LED_W-1:0] LED,
  output logic             TICK
);

  logic                r_dp_valid;
  logic                r_dp_write;
  logic [1:0]          r_dp_ofs;
  logic [c_CTRL_W-1:0] r_ctrl;
  logic [SPEED_W-1:0]  r_speed;

  logic                w_accept;
  logic                w_commit;
  logic                w_wr_ctrl;
  logic                w_wr_speed;
  logic [c_CTRL_W-1:0] w_ctrl_eff;
  logic                w_restart;
  logic [SPEED_W-1:0]  w_count;
  logic                w_unused;

  assign w_accept = HSEL && HTRANS[1] && HREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_ofs   <= '0;
    end else if (HREADY) begin
      r_dp_valid <= w_accept;
      r_dp_write <= HWRITE;
      r_dp_ofs   <= HADDR[3:2];
    end
  end

  assign w_commit   = r_dp_valid && r_dp_write && HREADY;
  assign w_wr_ctrl  = w_commit && (r_dp_ofs == c_OFS_CTRL);
  assign w_wr_speed = w_commit && (r_dp_ofs == c_OFS_SPEED);

  // The engine sees the CTRL value being committed so a restart loads the new mode's seed
  assign w_ctrl_eff = w_wr_ctrl ? HWDATA[c_CTRL_W-1:0] : r_ctrl;
  assign w_restart  = w_wr_ctrl && (HWDATA[c_CTRL_W-1:0] != r_ctrl);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_ctrl  <= '0;
      r_speed <= '0;
    end else begin
      if (w_wr_ctrl)  r_ctrl  <= HWDATA[c_CTRL_W-1:0];
      if (w_wr_speed) r_speed <= HWDATA[SPEED_W-1:0];
    end
  end

  waterlight_engine #(
    .LED_W   (LED_W),
    .SPEED_W (SPEED_W)
  ) u_engine (
    .clk     (HCLK),
    .rst     (HRESET),
    .en      (w_ctrl_eff[c_CTRL_EN_BIT]),
    .mode    (mode_e'(w_ctrl_eff[c_CTRL_MODE_LSB +: 2])),
    .speed   (r_speed),
    .restart (w_restart),
    .led     (LED),
    .tick    (TICK),
    .count   (w_count)
  );

  always_comb begin
    HRDATA = '0;
    if (r_dp_valid && !r_dp_write) begin
      case (r_dp_ofs)
        c_OFS_CTRL:    HRDATA = 32'(r_ctrl);
        c_OFS_SPEED:   HRDATA = 32'(r_speed);
        c_OFS_PATTERN: HRDATA = 32'(LED);
        c_OFS_COUNT:   HRDATA = 32'(w_count);
        default:       HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;

  assign w_unused = &{1'b0, HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

endmodule

`default_nettype wire

// File: tb/tb_ahblite_waterlight_ctrl.sv
// Self-checking bench for ahblite_waterlight_ctrl: scripted scenarios plus random traffic against a reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_ahblite_waterlight_ctrl;

  localparam int LED_W   = 8;
  localparam int SPEED_W = 6;
  localparam logic [31:0] A_CTRL = 32'h0, A_SPEED = 32'h4, A_PAT = 32'h8, A_CNT = 32'hC;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0] HTRANS = '0;
  logic [2:0] HSIZE = 3'b010;
  logic [3:0] HPROT = '0;
  logic HREADYOUT, HRESP, TICK;
  logic [31:0] HRDATA;
  logic [LED_W-1:0] LED;

  always #5 HCLK = ~HCLK;

  ahblite_waterlight_ctrl #(.LED_W(LED_W), .SPEED_W(SPEED_W)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .LED(LED), .TICK(TICK)
  );

  int n_checks = 0, n_fail = 0;

  // Reference model: pattern kept as a lit-bit position / blink phase
  int m_en = 0, m_mode = 0, m_speed = 0, m_count = 0, m_pos = 0;
  bit m_phase = 0;
  bit m_dp_valid = 0, m_dp_write = 0;
  int m_dp_ofs = 0;
  logic [31:0] pend_wdata = '0;
  logic [31:0] obs_rdata;
  logic [LED_W-1:0] obs_led;
  logic obs_tick;

  function automatic logic [31:0] model_led();
    if (!(m_en != 0 && m_mode != 0)) return 32'h0;
    if (m_mode == 3) return m_phase ? ((32'h1 << LED_W) - 1) : 32'h0;
    return 32'h1 << m_pos;
  endfunction

  task automatic step();
    bit commit, wctrl, wspeed, restart, act, exp_tick;
    int nen, nmode;
    logic [31:0] exp_rd, exp_led32;
    logic [LED_W-1:0] exp_led;
    commit = m_dp_valid && m_dp_write;
    wctrl  = commit && (m_dp_ofs == 0);
    wspeed = commit && (m_dp_ofs == 1);
    nen    = wctrl ? int'(HWDATA[0]) : m_en;
    nmode  = wctrl ? int'(HWDATA[2:1]) : m_mode;
    restart = wctrl && (nen != m_en || nmode != m_mode);
    act = (nen != 0) && (nmode != 0);
    exp_tick = act && !restart && (m_count == 0);
    exp_led32 = model_led();
    exp_led = exp_led32[LED_W-1:0];
    exp_rd = 32'h0;
    if (m_dp_valid && !m_dp_write) begin
      case (m_dp_ofs)
        0: exp_rd = 32'(m_en | (m_mode << 1));
        1: exp_rd = 32'(m_speed);
        2: exp_rd = exp_led32;
        default: exp_rd = 32'(m_count);
      endcase
    end
    @(negedge HCLK);
    obs_rdata = HRDATA; obs_led = LED; obs_tick = TICK;
    if (!HRESET) begin
      n_checks++;
      if (LED !== exp_led) begin n_fail++; $display("FAIL led @%0t: got %h want %h", $time, LED, exp_led); end
      n_checks++;
      if (TICK !== exp_tick) begin n_fail++; $display("FAIL tick @%0t: got %b want %b", $time, TICK, exp_tick); end
      n_checks++;
      if (HRDATA !== exp_rd) begin n_fail++; $display("FAIL hrdata @%0t: got %h want %h", $time, HRDATA, exp_rd); end
      n_checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
        n_fail++; $display("FAIL resp @%0t: got ready=%b resp=%b want 1/0", $time, HREADYOUT, HRESP);
      end
    end
    @(posedge HCLK);
    if (HRESET) begin
      m_en = 0; m_mode = 0; m_speed = 0; m_count = 0; m_pos = 0; m_phase = 0;
      m_dp_valid = 0; m_dp_write = 0; m_dp_ofs = 0;
    end else begin
      if (restart) begin
        m_count = m_speed;
        m_pos   = (nmode == 2) ? LED_W - 1 : 0;
        m_phase = 1;
      end else if (!act) begin
        m_count = m_speed;
      end else if (m_count == 0) begin
        m_count = m_speed;
        if (m_mode == 1) m_pos = (m_pos + 1) % LED_W;
        else if (m_mode == 2) m_pos = (m_pos + LED_W - 1) % LED_W;
        else m_phase = !m_phase;
      end else begin
        m_count--;
      end
      m_en = nen; m_mode = nmode;
      if (wspeed) m_speed = int'(HWDATA & ((32'h1 << SPEED_W) - 1));
      m_dp_valid = HSEL && HTRANS[1] && HREADY;
      m_dp_write = HWRITE;
      m_dp_ofs   = int'(HADDR[3:2]);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                       input bit wr, input logic [31:0] wdata);
    HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr;
    HWDATA = pend_wdata; pend_wdata = wdata;
    HPROT = 4'($urandom);
    step();
  endtask

  task automatic idle(); drive(1'b0, 2'b00, 32'h0, 1'b0, 32'h0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); drive(1'b1, 2'b10, a, 1'b1, d); idle(); endtask
  task automatic rd(input logic [31:0] a); drive(1'b1, 2'b10, a, 1'b0, 32'h0); idle(); endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (3) idle();
    HRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(32'(i * 4));
      n_checks++;
      if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_read ofs%0d: got %h want 0", i, obs_rdata); end
    end
    // write dropped by a reset that lands in its data phase
    drive(1'b1, 2'b10, A_CTRL, 1'b1, 32'h3);
    HRESET = 1'b1;
    idle();
    HRESET = 1'b0;
    rd(A_CTRL);
    n_checks++;
    if (obs_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_drop: got %h want 0", obs_rdata); end
  endtask

  task automatic test_rotl();
    int ticks = 0;
    wr(A_SPEED, 32'd3);
    wr(A_CTRL, 32'h3);
    idle();
    n_checks++;
    if (obs_led !== 8'h01) begin n_fail++; $display("FAIL rotl_init: got %h want 01", obs_led); end
    repeat (32) begin idle(); if (obs_tick) ticks++; end
    idle();
    n_checks++;
    if (ticks != 8 || obs_led !== 8'h01) begin
      n_fail++; $display("FAIL rotl_wrap: got ticks=%0d led=%h want 8/01", ticks, obs_led);
    end
  endtask

  task automatic test_rotr();
    wr(A_SPEED, 32'd0);
    wr(A_CTRL, 32'h5);
    drive(1'b1, 2'b10, A_PAT, 1'b0, 32'h0);
    n_checks++;
    if (obs_led !== 8'h80) begin n_fail++; $display("FAIL rotr_init: got %h want 80", obs_led); end
    repeat (10) drive(1'b1, 2'b10, A_PAT, 1'b0, 32'h0);
    idle();
  endtask

  task automatic test_blink();
    wr(A_CTRL, 32'h7);
    wr(A_SPEED, 32'd1);
    repeat (8) idle();
    wr(A_CTRL, 32'h0);
    rd(A_CNT);
    n_checks++;
    if (obs_rdata !== 32'd1) begin n_fail++; $display("FAIL blink_off_count: got %0d want 1", obs_rdata); end
  endtask

  task automatic test_tick_collision();
    int guard = 0;
    wr(A_SPEED, 32'd2);
    wr(A_CTRL, 32'h3);
    while (m_count != 1 && guard < 20) begin idle(); guard++; end
    n_checks++;
    if (guard >= 20) begin n_fail++; $display("FAIL collide_wait: got timeout want count==1"); end
    drive(1'b1, 2'b10, A_CTRL, 1'b1, 32'h5);
    idle();
    n_checks++;
    if (obs_tick !== 1'b0) begin n_fail++; $display("FAIL collide_tick: got %b want 0", obs_tick); end
    idle(); idle(); idle();
    n_checks++;
    if (obs_tick !== 1'b1 || obs_led !== 8'h80) begin
      n_fail++; $display("FAIL collide_next: got tick=%b led=%h want 1/80", obs_tick, obs_led);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    wr(A_SPEED, 32'd10);
    n = 0;
    do begin idle(); n++; end while (!obs_tick && n < 40);
    n = 0;
    do begin idle(); n++; end while (!obs_tick && n < 40);
    n_checks++;
    if (n != 11) begin n_fail++; $display("FAIL period: got %0d want 11", n); end
    wr(A_PAT, 32'hFF);
    rd(A_PAT);
    drive(1'b1, 2'b10, A_SPEED, 1'b1, 32'hFFFF_FFC0 | 32'd10);
    drive(1'b1, 2'b10, A_SPEED, 1'b0, 32'h0);
    idle();
    n_checks++;
    if (obs_rdata !== 32'd10) begin n_fail++; $display("FAIL b2b_speed: got %0d want 10", obs_rdata); end
  endtask

  task automatic test_random();
    int r, ofs;
    logic [31:0] a, d;
    repeat (400) begin
      r = $urandom_range(0, 9);
      ofs = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_FFF0) | 32'(ofs << 2);
      d = $urandom;
      if (ofs == 1) d = (d & 32'hFFFF_FFC0) | 32'($urandom_range(0, 4));
      case (r)
        0, 1, 2, 3: drive(1'b1, 2'b10 | 2'($urandom_range(0, 1)), a, 1'b1, d);
        4, 5, 6:    drive(1'b1, 2'b11, a, 1'b0, d);
        7:          drive(1'b0, 2'b10, a, 1'($urandom_range(0, 1)), d);
        8:          drive(1'b1, 2'b01, a, 1'b1, d);
        default:    idle();
      endcase
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rotl();
    test_rotr();
    test_blink();
    test_tick_collision();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
